// File: rtl/packed_field_streamer.sv
// Streams the fields of one packed word out, one field per beat, over valid/ready.
// Defining PACKED_FIELD_STREAMER_SKIP_ZERO_EN suppresses beats for all-zero fields.
module packed_field_streamer #(
  parameter int unsigned FIELD_W    = 2,
  parameter int unsigned NUM_FIELDS = 2,
  parameter int unsigned REVERSE    = 0,
  parameter int unsigned IDX_W      = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [FIELD_W*NUM_FIELDS-1:0] in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [FIELD_W-1:0]            out_field,
  output logic [IDX_W-1:0]              out_idx,
  output logic                          out_last
);
  localparam int unsigned WordW = FIELD_W * NUM_FIELDS;
  localparam logic [IDX_W-1:0] FirstIdx = (REVERSE != 0) ? IDX_W'(0) : IDX_W'(NUM_FIELDS - 1);
  localparam logic [IDX_W-1:0] LastIdx  = (REVERSE != 0) ? IDX_W'(NUM_FIELDS - 1) : IDX_W'(0);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e             state_q, state_d;
  logic [WordW-1:0]   word_q, word_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               is_last;
  logic               fire_out;
  logic               load;

  assign fire_out = out_valid && out_ready;
  assign load     = in_valid && in_ready;

`ifdef PACKED_FIELD_STREAMER_SKIP_ZERO_EN
  logic [NUM_FIELDS-1:0] rem_q, rem_d, rem_clr, nz_in;

  // First remaining field in emission order.
  function automatic logic [IDX_W-1:0] pick(input logic [NUM_FIELDS-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_FIELDS; k++) begin
      if (REVERSE == 0) begin
        if (m[k]) r = IDX_W'(k);
      end else if (m[NUM_FIELDS-1-k]) begin
        r = IDX_W'(NUM_FIELDS - 1 - k);
      end
    end
    return r;
  endfunction

  always_comb begin
    rem_clr = '0;
    nz_in   = '0;
    for (int k = 0; k < NUM_FIELDS; k++) begin
      rem_clr[k] = rem_q[k] && (idx_q != IDX_W'(k));
      nz_in[k]   = |in_data[k*FIELD_W +: FIELD_W];
    end
  end

  assign is_last = (rem_clr == '0);
`else
  assign is_last = (idx_q == LastIdx);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      word_q  <= '0;
      idx_q   <= '0;
`ifdef PACKED_FIELD_STREAMER_SKIP_ZERO_EN
      rem_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
`ifdef PACKED_FIELD_STREAMER_SKIP_ZERO_EN
      rem_q   <= rem_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
`ifdef PACKED_FIELD_STREAMER_SKIP_ZERO_EN
    rem_d   = rem_q;
    if (fire_out) begin
      if (is_last) begin
        state_d = StIdle;
      end else begin
        rem_d = rem_clr;
        idx_d = pick(rem_clr);
      end
    end
    if (load) begin
      // An all-zero word is swallowed without producing any beat.
      if (|nz_in) begin
        state_d = StEmit;
        word_d  = in_data;
        rem_d   = nz_in;
        idx_d   = pick(nz_in);
      end else begin
        state_d = StIdle;
      end
    end
`else
    if (fire_out) begin
      if (is_last) begin
        state_d = StIdle;
      end else if (REVERSE != 0) begin
        idx_d = idx_q + IDX_W'(1);
      end else begin
        idx_d = idx_q - IDX_W'(1);
      end
    end
    if (load) begin
      state_d = StEmit;
      word_d  = in_data;
      idx_d   = FirstIdx;
    end
`endif
  end

  // Reload is allowed in the same cycle the final beat is accepted.
  always_comb begin
    out_valid = (state_q == StEmit);
    out_field = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    if (out_valid) begin
      out_field = word_q[idx_q*FIELD_W +: FIELD_W];
      out_idx   = idx_q;
      out_last  = is_last;
    end
    in_ready = (state_q == StIdle) || (out_valid && out_ready && out_last);
  end

endmodule

// File: tb/tb_packed_field_streamer.sv
// Directed bench for packed_field_streamer: per-cycle vector table on the default
// configuration plus hand-written streams on 4-field forward/reverse instances.
module tb_packed_field_streamer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       a_iv, a_ir, a_ov, a_or, a_last;
  logic [3:0] a_d;
  logic [1:0] a_f;
  logic [0:0] a_idx;
  logic       r_iv, r_ir, r_ov, r_or, r_last;
  logic [7:0] r_d;
  logic [1:0] r_f, r_idx;
  logic       f_iv, f_ir, f_ov, f_or, f_last;
  logic [7:0] f_d;
  logic [1:0] f_f, f_idx;

  packed_field_streamer dut_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_d),
    .out_valid(a_ov), .out_ready(a_or), .out_field(a_f), .out_idx(a_idx), .out_last(a_last)
  );

  packed_field_streamer #(.FIELD_W(2), .NUM_FIELDS(4), .REVERSE(1)) dut_r (
    .clk(clk), .rst(rst), .in_valid(r_iv), .in_ready(r_ir), .in_data(r_d),
    .out_valid(r_ov), .out_ready(r_or), .out_field(r_f), .out_idx(r_idx), .out_last(r_last)
  );

  packed_field_streamer #(.FIELD_W(2), .NUM_FIELDS(4), .REVERSE(0)) dut_f (
    .clk(clk), .rst(rst), .in_valid(f_iv), .in_ready(f_ir), .in_data(f_d),
    .out_valid(f_ov), .out_ready(f_or), .out_field(f_f), .out_idx(f_idx), .out_last(f_last)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic       iv;
    logic [3:0] d;
    logic       ordy;
    logic       ir;
    logic       ov;
    logic [1:0] f;
    logic       idx;
    logic       last;
  } vec_t;

  vec_t vecs[17];

  // Start at a negedge with the instance idle; exp holds {field, idx} per beat, MSB first.
  task automatic stream4(input bit sel, input logic [7:0] data, input int n_exp,
                         input logic [15:0] exp, input string tag);
    int         got = 0;
    logic       v, ir, last;
    logic [1:0] fld, ix;
    if (sel) begin f_iv = 1'b1; f_d = data; f_or = 1'b1; end
    else     begin r_iv = 1'b1; r_d = data; r_or = 1'b1; end
    @(negedge clk);
    if (sel) f_iv = 1'b0; else r_iv = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      v    = sel ? f_ov   : r_ov;
      ir   = sel ? f_ir   : r_ir;
      last = sel ? f_last : r_last;
      fld  = sel ? f_f    : r_f;
      ix   = sel ? f_idx  : r_idx;
      if (c == 0) begin
        chk({tag, "_first_valid"}, 32'(v), 32'(n_exp > 0));
        chk({tag, "_in_ready"}, 32'(ir), 32'(n_exp == 0));
      end
      if (v) begin
        if (got < n_exp) begin
          chk($sformatf("%s_b%0d_field", tag, got), 32'(fld), 32'(exp[15-4*got -: 2]));
          chk($sformatf("%s_b%0d_idx", tag, got), 32'(ix), 32'(exp[13-4*got -: 2]));
          chk($sformatf("%s_b%0d_last", tag, got), 32'(last), 32'(got == n_exp - 1));
        end
        got++;
      end
      @(negedge clk);
    end
    chk({tag, "_beats"}, 32'(got), 32'(n_exp));
  endtask

  initial begin
    a_iv = 1'b0; a_d = '0; a_or = 1'b0;
    r_iv = 1'b0; r_d = '0; r_or = 1'b0;
    f_iv = 1'b0; f_d = '0; f_or = 1'b0;

    //            iv    d        or    ir    ov    f      idx   last
    vecs[0]  = {1'b1, 4'b1100, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
    vecs[1]  = {1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0};
    vecs[2]  = {1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1};
    vecs[3]  = {1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
    vecs[4]  = {1'b1, 4'b1100, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
    vecs[5]  = {1'b1, 4'b0011, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0};
    vecs[6]  = {1'b1, 4'b0011, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0};
    vecs[7]  = {1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0};
    vecs[8]  = {1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1};
    vecs[9]  = {1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1};
    vecs[10] = {1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
    vecs[11] = {1'b1, 4'b1100, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};
    vecs[12] = {1'b1, 4'b0110, 1'b1, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0};
    vecs[13] = {1'b1, 4'b0110, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1};
    vecs[14] = {1'b1, 4'b0110, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0};
    vecs[15] = {1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1};
    vecs[16] = {1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0};

    #1;
    chk("rst_a_valid", 32'(a_ov), 32'(0));
    chk("rst_a_field", 32'(a_f), 32'(0));
    chk("rst_a_idx", 32'(a_idx), 32'(0));
    chk("rst_a_last", 32'(a_last), 32'(0));
    chk("rst_r_valid", 32'(r_ov), 32'(0));
    chk("rst_f_valid", 32'(f_ov), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_a_in_ready", 32'(a_ir), 32'(1));
    @(negedge clk);

`ifndef PACKED_FIELD_STREAMER_SKIP_ZERO_EN
    for (int i = 0; i < 17; i++) begin
      a_iv = vecs[i].iv;
      a_d  = vecs[i].d;
      a_or = vecs[i].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(a_ir), 32'(vecs[i].ir));
      chk($sformatf("v%0d_valid", i), 32'(a_ov), 32'(vecs[i].ov));
      chk($sformatf("v%0d_field", i), 32'(a_f), 32'(vecs[i].f));
      chk($sformatf("v%0d_idx", i), 32'(a_idx), 32'(vecs[i].idx));
      chk($sformatf("v%0d_last", i), 32'(a_last), 32'(vecs[i].last));
      @(negedge clk);
    end
    a_iv = 1'b0;
`endif

    // Reset asserted between edges while the first beat is stalled.
    a_iv = 1'b1; a_d = 4'b1001; a_or = 1'b1;
    @(negedge clk);
    a_iv = 1'b0; a_or = 1'b0;
    #1;
    chk("mid_pre_valid", 32'(a_ov), 32'(1));
    chk("mid_pre_field", 32'(a_f), 32'(2'b10));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(a_ov), 32'(0));
    chk("mid_rst_field", 32'(a_f), 32'(0));
    chk("mid_rst_idx", 32'(a_idx), 32'(0));
    chk("mid_rst_last", 32'(a_last), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    a_iv = 1'b1; a_d = 4'b1001; a_or = 1'b1;
    @(negedge clk);
    a_iv = 1'b0;
    #1;
    chk("post_b0_field", 32'(a_f), 32'(2'b10));
    chk("post_b0_idx", 32'(a_idx), 32'(1));
    chk("post_b0_last", 32'(a_last), 32'(0));
    @(negedge clk);
    #1;
    chk("post_b1_field", 32'(a_f), 32'(2'b01));
    chk("post_b1_idx", 32'(a_idx), 32'(0));
    chk("post_b1_last", 32'(a_last), 32'(1));
    @(negedge clk);
    #1;
    chk("post_idle_valid", 32'(a_ov), 32'(0));
    @(negedge clk);

`ifdef PACKED_FIELD_STREAMER_SKIP_ZERO_EN
    stream4(1'b0, 8'b00_01_10_11, 3, 16'b11_00_10_01_01_10_0000, "rev");
    stream4(1'b1, 8'b00_11_00_01, 2, 16'b11_10_01_00_00000000, "fwd");
    stream4(1'b1, 8'h00, 0, 16'h0000, "zero");
`else
    stream4(1'b0, 8'b00_01_10_11, 4, 16'b11_00_10_01_01_10_00_11, "rev");
    stream4(1'b1, 8'b00_11_00_01, 4, 16'b00_11_11_10_00_01_01_00, "fwd");
    stream4(1'b1, 8'h00, 4, 16'h3210, "zero");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
